// File: rtl/mem_access_ctrl.sv
// Shares one single-port word memory between the instruction-fetch and data ports,
// with round-robin arbitration, optional wait states and read-modify-write for partial stores.
module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_enable,
   output logic        mem_wr,
   input  logic [31:0] mem_data_out,
   output logic        busy
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          last_grant;
   logic          sel_d;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   merged_q;
   logic [3:0]    be_q;
   logic          pick_d;
   logic [31:0]   merged;
   logic          unused_addr_bits;

   function automatic state_t access_state(input logic wr, input logic [3:0] be);
      if (!wr)
         return S_RD;
      else if (be == 4'hF)
         return S_WR;
      else if (be == 4'h0)
         return S_DONE;
      else
         return S_RMW_RD;
   endfunction

   // last_grant is 1 when the data port won most recently, so a tie goes to the other port
   assign pick_d = d_req && (!if_req || !last_grant);

   always_comb begin
      merged = mem_data_out;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i])
            merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         last_grant <= 1'b0;
         sel_d      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         merged_q   <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (if_req || d_req) begin
                  sel_d      <= pick_d;
                  last_grant <= pick_d;
                  wr_q       <= pick_d & d_wr;
                  addr_q     <= pick_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
                  wdata_q    <= d_wdata;
                  be_q       <= d_be;
                  wait_cnt   <= '0;
                  if (WAIT_CYCLES > 0)
                     state <= S_WAIT;
                  else
                     state <= access_state(pick_d & d_wr, d_be);
               end
            end
            S_WAIT: begin
               if (wait_cnt == CW'(WAIT_CYCLES - 1))
                  state <= access_state(wr_q, be_q);
               else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            S_RD: begin
               if (sel_d)
                  d_rdata <= mem_data_out;
               else
                  if_rdata <= mem_data_out;
               state <= S_DONE;
            end
            S_WR:     state <= S_DONE;
            S_RMW_RD: begin
               merged_q <= merged;
               state    <= S_RMW_WR;
            end
            S_RMW_WR: state <= S_DONE;
            S_DONE:   state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Memory strobes come only from state and latched request, never from live requester inputs
   always_comb begin
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_data_in = '0;
      case (state)
         S_RD, S_RMW_RD: mem_enable = 1'b1;
         S_WR: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_data_in = wdata_q;
         end
         S_RMW_WR: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_data_in = merged_q;
         end
         default: ;
      endcase
   end

   assign mem_addr         = addr_q;
   assign if_ready         = (state == S_DONE) && !sel_d;
   assign d_ready          = (state == S_DONE) && sel_d;
   assign busy             = (state != S_IDLE);
   assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration, latency and memory contents.
module tb_mem_access_ctrl;

   localparam int W = 1;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic        mem_enable;
   logic        mem_wr;
   logic [31:0] mem_data_out;
   logic        busy;

   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_data;
   logic [31:0] mem_arr [0:63];

   logic [31:0] ref_mem [0:63];
   logic [31:0] if_rdata_m;
   logic [31:0] d_rdata_m;
   bit          last_d_m;

   int n_checks;
   int n_fail;

   mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_ready     (if_ready),
      .if_rdata     (if_rdata),
      .d_req        (d_req),
      .d_wr         (d_wr),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_be         (d_be),
      .d_ready      (d_ready),
      .d_rdata      (d_rdata),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_enable   (mem_enable),
      .mem_wr       (mem_wr),
      .mem_data_out (mem_data_out),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Small word memory standing in for the real block; upper address bits alias
   always @(posedge clk) begin
      if (pre_we)
         mem_arr[pre_idx] <= pre_data;
      else if (mem_enable && mem_wr)
         mem_arr[mem_addr[7:2]] <= mem_data_in;
   end
   assign mem_data_out = mem_arr[mem_addr[7:2]];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int latency(input bit is_d, input bit wr, input logic [3:0] be);
      if (!is_d || !wr || be == 4'hF)
         return 2 + W;
      else if (be == 4'h0)
         return 1 + W;
      else
         return 3 + W;
   endfunction

   function automatic int mem_cycles(input bit wr, input logic [3:0] be);
      if (!wr || be == 4'hF)
         return 1;
      else if (be == 4'h0)
         return 0;
      else
         return 2;
   endfunction

   task automatic mergeStore(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      logic [5:0]  idx;
      logic [31:0] word;
      idx  = a[7:2];
      word = ref_mem[idx];
      for (int i = 0; i < 4; i++)
         if (be[i])
            word[8*i +: 8] = wd[8*i +: 8];
      ref_mem[idx] = word;
   endtask

   // One or two simultaneous requests, each served to completion; the model predicts grant order and timing
   task automatic applyStimulus(input bit do_f, input logic [31:0] fa,
                                input bit do_d, input bit dw, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [3:0] dbe);
      bit          pend_f;
      bit          pend_d;
      bit          cur_d;
      int          cyc;
      int          exp_n;
      int          n_en;
      int          n_wr;
      int          exp_en;
      int          exp_wr;
      logic [31:0] cur_addr;
      checkOutput("idle busy", 32'(busy), 32'd0);
      pend_f   = do_f;
      pend_d   = do_d;
      cur_d    = do_d && (!do_f || !last_d_m);
      last_d_m = cur_d;
      exp_n    = latency(cur_d, dw, dbe);
      exp_en   = (do_f ? 1 : 0) + (do_d ? mem_cycles(dw, dbe) : 0);
      exp_wr   = (do_d && dw && dbe != 4'h0) ? 1 : 0;
      if_req   = do_f;
      if_addr  = fa;
      d_req    = do_d;
      d_wr     = dw;
      d_addr   = da;
      d_wdata  = dwd;
      d_be     = dbe;
      cyc  = 0;
      n_en = 0;
      n_wr = 0;
      while ((pend_f || pend_d) && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         cur_addr = cur_d ? {da[31:2], 2'b00} : {fa[31:2], 2'b00};
         if (mem_enable) begin
            n_en++;
            if (mem_wr)
               n_wr++;
            checkOutput("mem_addr", mem_addr, cur_addr);
         end
         checkOutput("other ready", 32'(cur_d ? if_ready : d_ready), 32'd0);
         if (cyc != exp_n) begin
            checkOutput("ready early", 32'(cur_d ? d_ready : if_ready), 32'd0);
         end else begin
            checkOutput("ready pulse", 32'(cur_d ? d_ready : if_ready), 32'd1);
            if (cur_d) begin
               if (dw) begin
                  mergeStore(da, dwd, dbe);
                  checkOutput("mem word", mem_arr[da[7:2]], ref_mem[da[7:2]]);
               end else begin
                  d_rdata_m = ref_mem[da[7:2]];
               end
               pend_d = 1'b0;
               d_req  = 1'b0;
            end else begin
               if_rdata_m = ref_mem[fa[7:2]];
               pend_f     = 1'b0;
               if_req     = 1'b0;
            end
            checkOutput("if_rdata", if_rdata, if_rdata_m);
            checkOutput("d_rdata", d_rdata, d_rdata_m);
            if (pend_f || pend_d) begin
               cur_d    = pend_d;
               last_d_m = cur_d;
               exp_n    = cyc + 1 + latency(cur_d, dw, dbe);
            end
         end
      end
      checkOutput("all served", 32'(pend_f || pend_d), 32'd0);
      checkOutput("mem_enable cycles", 32'(n_en), 32'(exp_en));
      checkOutput("mem_wr cycles", 32'(n_wr), 32'(exp_wr));
      @(posedge clk);
      #1;
      checkOutput("post if_ready", 32'(if_ready), 32'd0);
      checkOutput("post d_ready", 32'(d_ready), 32'd0);
      checkOutput("post busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          cyc;
      int          last_cyc;
      int          nready;
      bit          exp_next_d;
      bit [1:0]    sel;
      int          bsel;
      logic [31:0] fa;
      logic [31:0] da;
      logic [31:0] wd;
      logic [3:0]  be;
      bit          dw;

      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      if_req     = 1'b0;
      if_addr    = '0;
      d_req      = 1'b0;
      d_wr       = 1'b0;
      d_addr     = '0;
      d_wdata    = '0;
      d_be       = '0;
      pre_we     = 1'b0;
      pre_idx    = '0;
      pre_data   = '0;
      if_rdata_m = '0;
      d_rdata_m  = '0;
      last_d_m   = 1'b0;

      // Preload memory while the controller is held in reset
      for (int i = 0; i < 64; i++) begin
         pre_idx  = 6'(i);
         pre_data = (i == 4) ? 32'h11223344 : $urandom();
         pre_we   = 1'b1;
         ref_mem[i] = pre_data;
         @(posedge clk);
         #1;
      end
      pre_we = 1'b0;

      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset if_ready", 32'(if_ready), 32'd0);
      checkOutput("reset d_ready", 32'(d_ready), 32'd0);
      checkOutput("reset mem_enable", 32'(mem_enable), 32'd0);
      checkOutput("reset mem_wr", 32'(mem_wr), 32'd0);
      checkOutput("reset mem_addr", mem_addr, 32'd0);
      checkOutput("reset mem_data_in", mem_data_in, 32'd0);
      checkOutput("reset if_rdata", if_rdata, 32'd0);
      checkOutput("reset d_rdata", d_rdata, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fetch, full store, partial store and empty store, then loads to confirm
      applyStimulus(1'b1, 32'h0000_0012, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      checkOutput("t1 fetch word", if_rdata, 32'h11223344);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'hF);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'h0);
      checkOutput("t2 load word", d_rdata, 32'hAABBCCDD);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0021, 32'h0000_0011, 4'b0001);
      checkOutput("t3 rmw word", mem_arr[8], 32'hAABBCC11);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0);
      checkOutput("t6 be0 word", mem_arr[8], 32'hAABBCC11);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'hF);
      checkOutput("t6 load word", d_rdata, 32'hAABBCC11);

      // Reset while a store to 0x30 sits in its wait state
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 32'h0000_0030;
      d_wdata = 32'hDEADBEEF;
      d_be    = 4'hF;
      @(posedge clk);
      #1;
      checkOutput("t5 busy before reset", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5 busy", 32'(busy), 32'd0);
      checkOutput("t5 mem_enable", 32'(mem_enable), 32'd0);
      checkOutput("t5 mem_wr", 32'(mem_wr), 32'd0);
      checkOutput("t5 mem_addr", mem_addr, 32'd0);
      checkOutput("t5 mem_data_in", mem_data_in, 32'd0);
      checkOutput("t5 d_ready", 32'(d_ready), 32'd0);
      checkOutput("t5 d_rdata", d_rdata, 32'd0);
      checkOutput("t5 if_rdata", if_rdata, 32'd0);
      d_req      = 1'b0;
      if_rdata_m = '0;
      d_rdata_m  = '0;
      last_d_m   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("t5 no d_ready", 32'(d_ready), 32'd0);
      end
      checkOutput("t5 mem unchanged", mem_arr[12], ref_mem[12]);

      // Both ports held continuously: grants alternate starting with data
      if_req     = 1'b1;
      if_addr    = 32'h0000_0010;
      d_req      = 1'b1;
      d_wr       = 1'b0;
      d_addr     = 32'h0000_0024;
      exp_next_d = 1'b1;
      nready     = 0;
      last_cyc   = 0;
      cyc        = 0;
      while (nready < 6 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (if_ready || d_ready) begin
            checkOutput("rr order", 32'(d_ready), 32'(exp_next_d));
            checkOutput("rr single", 32'(if_ready & d_ready), 32'd0);
            if (nready == 0)
               checkOutput("rr first", 32'(cyc), 32'(2 + W));
            else
               checkOutput("rr gap", 32'(cyc - last_cyc), 32'(3 + W));
            if (d_ready) begin
               d_rdata_m = ref_mem[9];
               checkOutput("rr d_rdata", d_rdata, d_rdata_m);
            end else begin
               if_rdata_m = ref_mem[4];
               checkOutput("rr if_rdata", if_rdata, if_rdata_m);
            end
            last_d_m   = d_ready;
            exp_next_d = !exp_next_d;
            last_cyc   = cyc;
            nready++;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      checkOutput("rr count", 32'(nready), 32'd6);
      @(posedge clk);
      #1;

      // Randomized single and simultaneous requests
      for (int k = 0; k < 40; k++) begin
         sel  = 2'($urandom_range(1, 3));
         fa   = $urandom();
         da   = $urandom();
         wd   = $urandom();
         dw   = 1'($urandom_range(0, 1));
         bsel = $urandom_range(0, 3);
         if (bsel == 0)
            be = 4'h0;
         else if (bsel == 1)
            be = 4'hF;
         else
            be = 4'($urandom_range(1, 14));
         applyStimulus(sel[0], fa, sel[1], dw, da, wd, be);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
